key_bounce_gen: RTL

- Synthesizable stimulus source that emulates mechanical push-button presses, including contact bounce, on up to N key lines.
- Drives the inputs of key_debounce in the Vision_Tester self-test path, replacing physical buttons during board bring-up and regression.
- One start pulse produces one press sequence: bounce-in, clean hold, bounce-out, release.
- Bounce timing comes from an internal LFSR, so runs are repeatable from reset.

---
 rtl/key_bounce_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/key_bounce_gen.sv
// key_bounce_gen
// Stimulus source that emulates mechanical push-button presses on up to N key
// lines, contact bounce included. It stands in for physical buttons in front
// of key_debounce during bring-up and regression. One accepted start produces
// one press: bounce-in, clean hold, bounce-out, release. Glitch segment
// lengths come from a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that is
// reseeded on reset, so every run after reset repeats the same pattern.
//
// Ports
//   clk       in   1      system clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      request one press sequence (sampled only in IDLE)
//   key_mask  in   N      lines to press, captured on accept
//   hold_len  in   CNT_W  clean hold duration, captured on accept
//   key_out   out  N      emulated key lines (registered)
//   busy      out  1      sequence in progress (state != IDLE)
//   done      out  1      one-cycle pulse when a sequence completes
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | lines released, waiting for start
// BIN   | bounce-in: BOUNCE_EDGES glitch toggles, then force pressed
// HOLD  | clean pressed level, hold_cnt counts down to zero
// BOUT  | bounce-out: BOUNCE_EDGES glitch toggles, then force released
//
// SEG_W must not exceed 16 (segment length is taken from the LFSR).

module key_bounce_gen #(
    parameter int   N            = 1,
    parameter int   CNT_W        = 32,
    parameter int   SEG_W        = 8,
    parameter int   BOUNCE_EDGES = 6,
    parameter logic IDLE_LEVEL   = 1'b0,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     key_mask,
    input  logic [CNT_W-1:0] hold_len,
    output logic [N-1:0]     key_out,
    output logic             busy,
    output logic             done
);

    localparam int   EDGE_W  = (BOUNCE_EDGES < 1) ? 1 : $clog2(BOUNCE_EDGES + 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(BOUNCE_EDGES);
    localparam logic PRESSED = ~IDLE_LEVEL;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIN  = 2'd1,
        HOLD = 2'd2,
        BOUT = 2'd3
    } state_t;

    state_t            state,    state_nxt;
    logic [N-1:0]      key_nxt;
    logic              done_nxt;
    logic [15:0]       lfsr,     lfsr_nxt;
    logic [EDGE_W-1:0] edge_cnt, edge_nxt;
    logic [SEG_W-1:0]  seg_cnt,  seg_nxt;
    logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic [N-1:0]      mask_r,   mask_nxt;
    logic [CNT_W-1:0]  hold_r,   hold_r_nxt;

    // Right-shifting Galois form: the bit shifted out feeds back into the taps.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        if (v[0]) begin
            return (v >> 1) ^ LFSR_TAPS;
        end
        return v >> 1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            key_out  <= {N{IDLE_LEVEL}};
            done     <= 1'b0;
            lfsr     <= SEED;
            edge_cnt <= '0;
            seg_cnt  <= '0;
            hold_cnt <= '0;
            mask_r   <= '0;
            hold_r   <= '0;
        end else begin
            state    <= state_nxt;
            key_out  <= key_nxt;
            done     <= done_nxt;
            lfsr     <= lfsr_nxt;
            edge_cnt <= edge_nxt;
            seg_cnt  <= seg_nxt;
            hold_cnt <= hold_cnt_nxt;
            mask_r   <= mask_nxt;
            hold_r   <= hold_r_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        key_nxt      = key_out;
        done_nxt     = 1'b0;
        lfsr_nxt     = lfsr;
        edge_nxt     = edge_cnt;
        seg_nxt      = seg_cnt;
        hold_cnt_nxt = hold_cnt;
        mask_nxt     = mask_r;
        hold_r_nxt   = hold_r;

        case (state)
            IDLE: begin
                if (start) begin
                    mask_nxt   = key_mask;
                    hold_r_nxt = hold_len;
                    edge_nxt   = '0;
                    seg_nxt    = '0;
                    // An empty mask has nothing to press: stay idle and
                    // complete immediately, done is high in the next cycle.
                    if (key_mask == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = BIN;
                    end
                end
            end

            BIN, BOUT: begin
                if (seg_cnt != '0) begin
                    seg_nxt = seg_cnt - 1'b1;
                end else if (edge_cnt != EDGE_LAST) begin
                    // Glitch: flip the selected lines and draw the length of
                    // the next segment (value + 1 cycles) from the LFSR.
                    key_nxt  = key_out ^ mask_r;
                    edge_nxt = edge_cnt + 1'b1;
                    seg_nxt  = lfsr[SEG_W-1:0];
                    lfsr_nxt = lfsr_adv(lfsr);
                end else if (state == BIN) begin
                    key_nxt      = (key_out & ~mask_r) | (mask_r & {N{PRESSED}});
                    hold_cnt_nxt = hold_r;
                    state_nxt    = HOLD;
                end else begin
                    key_nxt   = (key_out & ~mask_r) | (mask_r & {N{IDLE_LEVEL}});
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            HOLD: begin
                // Pressed level lasts hold_r + 2 cycles: the forcing cycle,
                // hold_r countdown cycles and the hand-off cycle into BOUT.
                if (hold_cnt != '0) begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                end else begin
                    edge_nxt  = '0;
                    seg_nxt   = '0;
                    state_nxt = BOUT;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
